// File: rtl/battle_pkg.sv
// Shared types and helpers for the battle front scanner.
package battle_pkg;

    localparam int unsigned TYPE_NONE = 0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        ADJUST = 2'd2,
        DONE   = 2'd3
    } state_e;

    // Select value that points at the tower rather than a unit slot.
    function automatic int unsigned tower_sel(input int unsigned num_slots);
        return num_slots;
    endfunction

endpackage

// File: rtl/battle_front_scan_if.sv
// Request/result bundle between a requester and battle_front_scan.
interface battle_front_scan_if #(
    parameter int unsigned NUM_SLOTS = 16,
    parameter int unsigned LOC_W     = 9,
    parameter int unsigned TYPE_W    = 2
);
    localparam int unsigned SEL_W = $clog2(NUM_SLOTS) + 1;

    logic                        Start;
    logic                        Ack;
    logic [NUM_SLOTS*LOC_W-1:0]  unitLocs;
    logic [NUM_SLOTS*LOC_W-1:0]  enemyLocs;
    logic [NUM_SLOTS*TYPE_W-1:0] unitTypes;
    logic [NUM_SLOTS*TYPE_W-1:0] enemyTypes;
    logic [LOC_W-1:0]            friendlyFront;
    logic [LOC_W-1:0]            enemyFront;
    logic [SEL_W-1:0]            unitDamageSelect;
    logic [SEL_W-1:0]            enemyDamageSelect;
    logic [SEL_W-1:0]            unitCount;
    logic [SEL_W-1:0]            enemyCount;
    logic                        contact;
    logic                        Done;

    modport master (
        output Start, Ack, unitLocs, enemyLocs, unitTypes, enemyTypes,
        input  friendlyFront, enemyFront, unitDamageSelect, enemyDamageSelect,
               unitCount, enemyCount, contact, Done
    );

    modport slave (
        input  Start, Ack, unitLocs, enemyLocs, unitTypes, enemyTypes,
        output friendlyFront, enemyFront, unitDamageSelect, enemyDamageSelect,
               unitCount, enemyCount, contact, Done
    );

endinterface

// File: rtl/front_slot_mux.sv
// Picks one slot's location and type out of a packed per-side bus.
module front_slot_mux #(
    parameter int unsigned NUM_SLOTS = 16,
    parameter int unsigned LOC_W     = 9,
    parameter int unsigned TYPE_W    = 2,
    localparam int unsigned IDX_W    = $clog2(NUM_SLOTS)
) (
    input  logic [NUM_SLOTS*LOC_W-1:0]  locs,
    input  logic [NUM_SLOTS*TYPE_W-1:0] types,
    input  logic [IDX_W-1:0]            idx,
    output logic [LOC_W-1:0]            loc_c,
    output logic [TYPE_W-1:0]           type_c
);

    always_comb begin
        loc_c  = '0;
        type_c = '0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            if (idx == IDX_W'(i)) begin
                loc_c  = locs[i*LOC_W +: LOC_W];
                type_c = types[i*TYPE_W +: TYPE_W];
            end
        end
    end

endmodule

// File: rtl/battle_front_scan.sv
// Scans both armies one slot per cycle to find each side's front and its contact state.
// Define BATTLE_FRONT_COUNT_EN to enable the live-unit counters.
module battle_front_scan
    import battle_pkg::*;
#(
    parameter int unsigned NUM_SLOTS = 16,
    parameter int unsigned LOC_W     = 9,
    parameter int unsigned TYPE_W    = 2,
    parameter int unsigned MARGIN    = 10
) (
    input  logic              clk,
    input  logic              rst,
    battle_front_scan_if.slave bus
);

    localparam int unsigned SEL_W = $clog2(NUM_SLOTS) + 1;
    localparam int unsigned IDX_W = SEL_W - 1;
    localparam logic [SEL_W-1:0] TOWER    = SEL_W'(tower_sel(NUM_SLOTS));
    localparam logic [SEL_W-1:0] SCAN_END = SEL_W'(NUM_SLOTS);
    localparam logic [LOC_W-1:0] LOC_ONES = '1;
    localparam logic [LOC_W:0]   MARGIN_X = (LOC_W+1)'(MARGIN);

    state_e state_q, state_d;

    logic [SEL_W-1:0] i_q, i_d;
    logic [LOC_W-1:0] friendly_front_q, friendly_front_d;
    logic [LOC_W-1:0] enemy_front_q, enemy_front_d;
    logic [SEL_W-1:0] unit_sel_q, unit_sel_d;
    logic [SEL_W-1:0] enemy_sel_q, enemy_sel_d;
    logic             contact_q, contact_d;
    logic             done_q, done_d;

    logic [LOC_W-1:0]  u_loc_c, e_loc_c;
    logic [TYPE_W-1:0] u_type_c, e_type_c;
    logic              u_live_c, e_live_c, scanning_c, start_ok_c;
    logic [LOC_W:0]    friendly_sub_c, enemy_add_c;
    logic [LOC_W-1:0]  friendly_adj_c, enemy_adj_c;

    front_slot_mux #(.NUM_SLOTS(NUM_SLOTS), .LOC_W(LOC_W), .TYPE_W(TYPE_W)) u_unit_mux (
        .locs   (bus.unitLocs),
        .types  (bus.unitTypes),
        .idx    (i_q[IDX_W-1:0]),
        .loc_c  (u_loc_c),
        .type_c (u_type_c)
    );

    front_slot_mux #(.NUM_SLOTS(NUM_SLOTS), .LOC_W(LOC_W), .TYPE_W(TYPE_W)) u_enemy_mux (
        .locs   (bus.enemyLocs),
        .types  (bus.enemyTypes),
        .idx    (i_q[IDX_W-1:0]),
        .loc_c  (e_loc_c),
        .type_c (e_type_c)
    );

    assign u_live_c   = (u_type_c != TYPE_W'(TYPE_NONE));
    assign e_live_c   = (e_type_c != TYPE_W'(TYPE_NONE));
    assign scanning_c = (state_q == SCAN) && (i_q != SCAN_END);
    assign start_ok_c = (state_q == IDLE) && bus.Start;

    // Margin adjust with one guard bit: borrow clamps to 0, carry clamps to all-ones.
    assign friendly_sub_c = {1'b0, friendly_front_q} - MARGIN_X;
    assign enemy_add_c    = {1'b0, enemy_front_q} + MARGIN_X;
    assign friendly_adj_c = friendly_sub_c[LOC_W] ? '0 : friendly_sub_c[LOC_W-1:0];
    assign enemy_adj_c    = enemy_add_c[LOC_W] ? LOC_ONES : enemy_add_c[LOC_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.Start) state_d = SCAN;
            SCAN:    if (i_q == SCAN_END) state_d = ADJUST;
            ADJUST:  state_d = DONE;
            DONE:    if (bus.Ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        i_d              = i_q;
        friendly_front_d = friendly_front_q;
        enemy_front_d    = enemy_front_q;
        unit_sel_d       = unit_sel_q;
        enemy_sel_d      = enemy_sel_q;
        contact_d        = contact_q;
        done_d           = (state_d == DONE);
        if (start_ok_c) begin
            i_d              = '0;
            friendly_front_d = LOC_ONES;
            enemy_front_d    = '0;
            unit_sel_d       = TOWER;
            enemy_sel_d      = TOWER;
            contact_d        = 1'b0;
        end else if (scanning_c) begin
            i_d = i_q + SEL_W'(1);
            // Strict compares keep the lowest index on ties.
            if (u_live_c && (u_loc_c < friendly_front_q)) begin
                friendly_front_d = u_loc_c;
                unit_sel_d       = i_q;
            end
            if (e_live_c && (e_loc_c > enemy_front_q)) begin
                enemy_front_d = e_loc_c;
                enemy_sel_d   = i_q;
            end
        end else if (state_q == ADJUST) begin
            friendly_front_d = friendly_adj_c;
            enemy_front_d    = enemy_adj_c;
            contact_d        = (enemy_adj_c >= friendly_adj_c);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_q              <= '0;
            friendly_front_q <= LOC_ONES;
            enemy_front_q    <= '0;
            unit_sel_q       <= TOWER;
            enemy_sel_q      <= TOWER;
            contact_q        <= 1'b0;
            done_q           <= 1'b0;
        end else begin
            i_q              <= i_d;
            friendly_front_q <= friendly_front_d;
            enemy_front_q    <= enemy_front_d;
            unit_sel_q       <= unit_sel_d;
            enemy_sel_q      <= enemy_sel_d;
            contact_q        <= contact_d;
            done_q           <= done_d;
        end
    end

`ifdef BATTLE_FRONT_COUNT_EN
    logic [SEL_W-1:0] unit_cnt_q, unit_cnt_d;
    logic [SEL_W-1:0] enemy_cnt_q, enemy_cnt_d;

    always_comb begin
        unit_cnt_d  = unit_cnt_q;
        enemy_cnt_d = enemy_cnt_q;
        if (start_ok_c) begin
            unit_cnt_d  = '0;
            enemy_cnt_d = '0;
        end else if (scanning_c) begin
            if (u_live_c) unit_cnt_d  = unit_cnt_q + SEL_W'(1);
            if (e_live_c) enemy_cnt_d = enemy_cnt_q + SEL_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            unit_cnt_q  <= '0;
            enemy_cnt_q <= '0;
        end else begin
            unit_cnt_q  <= unit_cnt_d;
            enemy_cnt_q <= enemy_cnt_d;
        end
    end

    assign bus.unitCount  = unit_cnt_q;
    assign bus.enemyCount = enemy_cnt_q;
`else
    assign bus.unitCount  = '0;
    assign bus.enemyCount = '0;
`endif

    assign bus.friendlyFront     = friendly_front_q;
    assign bus.enemyFront        = enemy_front_q;
    assign bus.unitDamageSelect  = unit_sel_q;
    assign bus.enemyDamageSelect = enemy_sel_q;
    assign bus.contact           = contact_q;
    assign bus.Done              = done_q;

endmodule
